// File: rtl/pool_row_feeder_if.sv
// Pixel-in / pooled-pair-out bundle between the activation stream, the row feeder and the
// 2x2 max-pool stage.
interface pool_row_feeder_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28
);
  localparam int unsigned NumPool = IMG_W * IMG_H / 4;
  localparam int unsigned IdxW    = (NumPool > 1) ? $clog2(NumPool) : 1;

  logic                        in_valid;
  logic signed [BIT_WIDTH-1:0] in_data;
  logic signed [BIT_WIDTH-1:0] row1_out;
  logic signed [BIT_WIDTH-1:0] row2_out;
  logic                        pool_en;
  logic                        pool_valid;
  logic [IdxW-1:0]             pool_idx;
  logic                        frame_done;

  modport master (
    output in_valid, in_data,
    input  row1_out, row2_out, pool_en, pool_valid, pool_idx, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output row1_out, row2_out, pool_en, pool_valid, pool_idx, frame_done
  );
endinterface

// File: rtl/pool_row_feeder.sv
// Line-buffered row pairer for a 2x2 max-pool: stores even rows, and on odd rows presents
// vertically aligned pixel pairs plus stride-2 valid flags and pooled-pixel indices.
module pool_row_feeder #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28
) (
  input logic         clk,
  input logic         rst,
  pool_row_feeder_if.slave bus
);
  localparam int unsigned NumPool = IMG_W * IMG_H / 4;
  localparam int unsigned ColW    = $clog2(IMG_W);
  localparam int unsigned RowW    = $clog2(IMG_H);
  localparam int unsigned IdxW    = (NumPool > 1) ? $clog2(NumPool) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumPool - 1);

  logic signed [BIT_WIDTH-1:0] line_buf [IMG_W];

  logic [ColW-1:0]             col_q;
  logic [RowW-1:0]             row_q;
  logic [IdxW-1:0]             idx_q;
  logic [IdxW-1:0]             idx_adv;
  logic signed [BIT_WIDTH-1:0] row1_q;
  logic signed [BIT_WIDTH-1:0] row2_q;
  logic                        pool_en_q;
  logic                        pair_q;
  logic                        pool_valid_q;
  logic                        frame_done_q;
  logic                        odd_acc;
  logic                        even_acc;

  assign odd_acc  = bus.in_valid & row_q[0];
  assign even_acc = bus.in_valid & ~row_q[0];

  // No reset: every entry is rewritten on an even row before any odd row reads it.
  always_ff @(posedge clk) begin
    if (even_acc) begin
      line_buf[col_q] <= bus.in_data;
    end
  end

  always_comb begin
    idx_adv = idx_q;
    if (pool_valid_q) begin
      idx_adv = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      idx_q        <= '0;
      row1_q       <= '0;
      row2_q       <= '0;
      pool_en_q    <= 1'b0;
      pair_q       <= 1'b0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pool_en_q <= odd_acc;
      if (odd_acc) begin
        row1_q <= line_buf[col_q];
        row2_q <= bus.in_data;
      end

      if (bus.in_valid) begin
        if (col_q == ColLast) begin
          col_q <= '0;
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // Stage 1 aligns with the pool stage latch, stage 2 with its registered max.
      pair_q       <= odd_acc & col_q[0];
      pool_valid_q <= pair_q;
      frame_done_q <= pair_q & (idx_adv == IdxLast);
      idx_q        <= idx_adv;
    end
  end

  assign bus.row1_out   = row1_q;
  assign bus.row2_out   = row2_q;
  assign bus.pool_en    = pool_en_q;
  assign bus.pool_valid = pool_valid_q;
  assign bus.pool_idx   = idx_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_row_feeder.sv
// Bench for pool_row_feeder: a 4x4 instance driven from a cycle table plus directed
// sequences, and a 28x28 instance driven randomly against a 2x2 max-pool frame model.
module tb_pool_row_feeder;
  localparam int unsigned BW  = 16;
  localparam int unsigned SW  = 4;
  localparam int unsigned SH  = 4;
  localparam int unsigned LW  = 28;
  localparam int unsigned LH  = 28;
  localparam int unsigned LNP = LW * LH / 4;
  localparam int unsigned LNX = LW * LH;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_l;
  always #5 clk = ~clk;

  pool_row_feeder_if #(.BIT_WIDTH(BW), .IMG_W(SW), .IMG_H(SH)) bs ();
  pool_row_feeder_if #(.BIT_WIDTH(BW), .IMG_W(LW), .IMG_H(LH)) bl ();

  pool_row_feeder #(.BIT_WIDTH(BW), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bs.slave)
  );

  pool_row_feeder #(.BIT_WIDTH(BW), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk (clk),
    .rst (rst_l),
    .bus (bl.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic signed [BW-1:0] max4(input logic signed [BW-1:0] a,
                                                 input logic signed [BW-1:0] b,
                                                 input logic signed [BW-1:0] c,
                                                 input logic signed [BW-1:0] d);
    logic signed [BW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Downstream 2x2 max-pool stand-ins: shift a pair on pool_en, register the window max.
  logic signed [BW-1:0] sp1, sp2, smx, lp1, lp2, lmx;
  always @(posedge clk) begin
    if (bs.pool_en) begin
      sp1 <= bs.row1_out;
      sp2 <= bs.row2_out;
      smx <= max4(bs.row1_out, bs.row2_out, sp1, sp2);
    end
    if (bl.pool_en) begin
      lp1 <= bl.row1_out;
      lp2 <= bl.row2_out;
      lmx <= max4(bl.row1_out, bl.row2_out, lp1, lp2);
    end
  end

  // ---------------- 28x28 reference: frame position and expected pooled outputs
  typedef struct {
    logic signed [BW-1:0] val;
    int                   idx;
  } exp_t;
  exp_t q[$];
  int   l_cnt;
  logic l_exp_en;
  int   n_pv = 0;
  int   n_fd = 0;

  always @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      l_cnt    <= 0;
      l_exp_en <= 1'b0;
    end else begin
      l_exp_en <= bl.in_valid && (((l_cnt / LW) % 2) == 1);
      if (bl.in_valid) l_cnt <= (l_cnt + 1) % LNX;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("l_pool_en", bl.pool_en, l_exp_en);
    if (bl.frame_done) n_fd++;
    if (bl.pool_valid) begin
      n_pv++;
      if (q.size() == 0) begin
        check("l_pv_queue", q.size(), 1);
      end else begin
        e = q.pop_front();
        check($sformatf("l_val_idx%0d", e.idx), longint'(lmx), longint'(e.val));
        check("l_pool_idx", bl.pool_idx, e.idx);
        check("l_frame_done", bl.frame_done, (e.idx == LNP - 1) ? 1 : 0);
      end
    end else begin
      check("l_fd_idle", bl.frame_done, 0);
    end
  end

  // Drives the first n_pix pixels of a random frame; queues windows they complete.
  task automatic drive_l(input int n_pix, input bit gaps);
    logic signed [BW-1:0] pix [LNX];
    exp_t e;
    for (int k = 0; k < LNX; k++) pix[k] = BW'($urandom);
    for (int r = 0; r < LH / 2; r++) begin
      for (int c = 0; c < LW / 2; c++) begin
        if ((2 * r + 1) * LW + 2 * c + 1 < n_pix) begin
          e.val = max4(pix[2 * r * LW + 2 * c], pix[2 * r * LW + 2 * c + 1],
                       pix[(2 * r + 1) * LW + 2 * c], pix[(2 * r + 1) * LW + 2 * c + 1]);
          e.idx = r * (LW / 2) + c;
          q.push_back(e);
        end
      end
    end
    for (int k = 0; k < n_pix; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 40) begin
          bl.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bl.in_valid = 1'b1;
      bl.in_data  = pix[k];
      @(posedge clk);
      #1;
    end
    bl.in_valid = 1'b0;
  endtask

  task automatic drain_l(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(name, q.size(), 0);
  endtask

  // ---------------- 4x4 cycle table: pixels 0..15 back to back
  typedef struct {
    bit v;
    int d;
    bit en;
    int r1;
    int r2;
    bit pv;
    int idx;
    bit fd;
    int mx;
  } vec_t;
  vec_t tab [19];

  task automatic run_table(input string tag);
    for (int i = 0; i < 19; i++) begin
      bs.in_valid = tab[i].v;
      bs.in_data  = BW'(tab[i].d);
      @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, i),
            {bs.pool_en, bs.row1_out, bs.row2_out, bs.pool_valid, bs.pool_idx, bs.frame_done},
            {tab[i].en, BW'(tab[i].r1), BW'(tab[i].r2), tab[i].pv, 2'(tab[i].idx), tab[i].fd});
      if (tab[i].pv) check($sformatf("%s_max%0d", tag, i), longint'(smx), tab[i].mx);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sv [16];
    int n_fd0;
    for (int i = 0; i < 5; i++) tab[i] = '{1, i, 0, 0, 0, 0, 0, 0, 0};
    tab[5]  = '{1, 5, 1, 0, 4, 0, 0, 0, 0};
    tab[6]  = '{1, 6, 1, 1, 5, 0, 0, 0, 0};
    tab[7]  = '{1, 7, 1, 2, 6, 1, 0, 0, 5};
    tab[8]  = '{1, 8, 1, 3, 7, 0, 1, 0, 0};
    tab[9]  = '{1, 9, 0, 3, 7, 1, 1, 0, 7};
    tab[10] = '{1, 10, 0, 3, 7, 0, 2, 0, 0};
    tab[11] = '{1, 11, 0, 3, 7, 0, 2, 0, 0};
    tab[12] = '{1, 12, 0, 3, 7, 0, 2, 0, 0};
    tab[13] = '{1, 13, 1, 8, 12, 0, 2, 0, 0};
    tab[14] = '{1, 14, 1, 9, 13, 0, 2, 0, 0};
    tab[15] = '{1, 15, 1, 10, 14, 1, 2, 0, 13};
    tab[16] = '{0, 0, 1, 11, 15, 0, 3, 0, 0};
    tab[17] = '{0, 0, 0, 11, 15, 1, 3, 1, 15};
    tab[18] = '{0, 0, 0, 11, 15, 0, 0, 0, 0};
    sv = '{-3, -8, -50, -60, -1, -20, -70, -80, -5, -6, -7, -9, -10, -11, -12, -13};

    rst_s = 1'b1;
    rst_l = 1'b1;
    bs.in_valid = 1'b0;
    bs.in_data  = '0;
    bl.in_valid = 1'b0;
    bl.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("s_reset_state",
          {bs.pool_en, bs.row1_out, bs.row2_out, bs.pool_valid, bs.pool_idx, bs.frame_done}, 0);
    rst_s = 1'b0;

    run_table("tab");

    // Signed window: upper row {-3,-8}, lower row {-1,-20}
    for (int i = 0; i < 19; i++) begin
      bs.in_valid = (i < 16);
      bs.in_data  = (i < 16) ? BW'(sv[i]) : '0;
      @(negedge clk);
      if (i == 5) begin
        check("sgn_row1", longint'(bs.row1_out), -3);
        check("sgn_row2", longint'(bs.row2_out), -1);
      end
      if (i == 7) begin
        check("sgn_pv", bs.pool_valid, 1);
        check("sgn_max", longint'(smx), -1);
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle while a pair is on the outputs
    for (int i = 0; i < 6; i++) begin
      bs.in_valid = 1'b1;
      bs.in_data  = BW'(100 + i);
      @(posedge clk);
      #1;
    end
    bs.in_valid = 1'b0;
    #2;
    check("arst_pre_en", bs.pool_en, 1);
    rst_s = 1'b1;
    #1;
    check("arst_outputs",
          {bs.pool_en, bs.row1_out, bs.row2_out, bs.pool_valid, bs.pool_idx, bs.frame_done}, 0);
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    run_table("post_rst");

    // 28x28: random gaps over a full frame
    rst_l = 1'b0;
    drive_l(LNX, 1'b1);
    drain_l("l_gap_drain");
    check("l_gap_pv_count", n_pv, LNP);
    check("l_gap_fd_count", n_fd, 1);

    // Reset after 37 pixels, then a clean frame
    drive_l(37, 1'b1);
    drain_l("l_part_drain");
    #2;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    check("l_rst_idx", bl.pool_idx, 0);
    rst_l = 1'b0;
    drive_l(LNX, 1'b1);
    drain_l("l_after_rst_drain");

    // Two frames back to back, no idle cycle
    n_fd0 = n_fd;
    drive_l(LNX, 1'b0);
    drive_l(LNX, 1'b0);
    drain_l("l_b2b_drain");
    check("l_b2b_fd_count", n_fd - n_fd0, 2);
    check("l_b2b_idx_wrap", bl.pool_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
